pixel_stream_sink: RTL and testbench

PIXEL_STREAM_SINK -- requirements
Module: pixel_stream_sink

---
 rtl/pixel_stream_pkg.sv | 27 ++
 rtl/pixel_stream_if.sv | 20 ++
 rtl/stall_lfsr.sv | 30 +++
 rtl/pixel_stream_sink.sv | 163 ++++++++++++++++
 tb/tb_pixel_stream_sink.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream sink: default frame geometry, FSM state
// encoding, sticky error flag bit positions and small helpers.
package pixel_stream_pkg;

  localparam int unsigned X_SIZE_DEF = 640;
  localparam int unsigned Y_SIZE_DEF = 480;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_ACTIVE   = 1'b1
  } state_e;

  // err_flags = {keep, eol_late, eol_early, sof_early, sof_missing}
  localparam int ERR_SOF_MISSING = 0;
  localparam int ERR_SOF_EARLY   = 1;
  localparam int ERR_EOL_EARLY   = 2;
  localparam int ERR_EOL_LATE    = 3;
  localparam int ERR_KEEP        = 4;
  localparam int ERR_W           = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_stream_if.sv
// Video stream bus carried into the sink. A beat transfers in the cycle where
// tvalid and tready are both 1; tuser marks start of frame, tlast marks end of line.
interface pixel_stream_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata, tkeep, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/stall_lfsr.sv
// Pseudo-random backpressure source; present only when PIXEL_SINK_STALL_EN is defined.
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stall asserted when the low two bits are 00.
`ifdef PIXEL_SINK_STALL_EN
module stall_lfsr
  import pixel_stream_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic stall_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule
`endif

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: tracks frame position, checksums frames, counts dropped beats and
// records sticky framing errors. Define PIXEL_SINK_STALL_EN for LFSR-driven backpressure.
module pixel_stream_sink
  import pixel_stream_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DEF,
  parameter int unsigned Y_SIZE = Y_SIZE_DEF
) (
  input  logic              in_stream_aclk,
  input  logic              in_stream_areset,
  pixel_stream_if.slave     in_stream,
  input  logic              err_clear,
  output logic [ERR_W-1:0]  err_flags,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [31:0]       frame_checksum,
  output logic [15:0]       dropped_beats,
  output logic [0:0]        dbg_state_o
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  localparam logic [0:0] WAIT_SOF = ST_WAIT_SOF;
  localparam logic [0:0] ACTIVE   = ST_ACTIVE;

  logic [0:0]       state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      chk_q, chk_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic             done_q, done_d;
  logic [1:0]       rdy_pipe_q;

  logic             stall;
  logic             tready;
  logic             accept;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic [31:0]      cur_sum;
  logic             eol;
  logic [ERR_W-1:0] err_new;

`ifdef PIXEL_SINK_STALL_EN
  stall_lfsr u_stall_lfsr (
    .clk     (in_stream_aclk),
    .rst     (in_stream_areset),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Two-stage enable keeps tready low through the first full cycle after reset release.
  assign tready           = rdy_pipe_q[1] & ~stall;
  assign in_stream.tready = tready;
  assign accept           = in_stream.tvalid & tready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    done_d  = 1'b0;
    err_new = '0;
    cur_x   = x_q;
    cur_y   = y_q;
    cur_sum = sum_q + in_stream.tdata;
    eol     = 1'b0;

    if (accept) begin
      if (in_stream.tkeep != 4'hF) begin
        err_new[ERR_KEEP] = 1'b1;
      end

      if (state_q == WAIT_SOF && !in_stream.tuser) begin
        err_new[ERR_SOF_MISSING] = 1'b1;
        drop_d = sat_inc16(drop_q);
      end else begin
        // A start-of-frame beat always becomes pixel (0,0) and reseeds the checksum.
        if (in_stream.tuser) begin
          if (state_q == ACTIVE && (x_q != '0 || y_q != '0)) begin
            err_new[ERR_SOF_EARLY] = 1'b1;
          end
          cur_x   = '0;
          cur_y   = '0;
          cur_sum = in_stream.tdata;
        end

        eol = in_stream.tlast || (cur_x == X_LAST);
        if (in_stream.tlast && cur_x != X_LAST) begin
          err_new[ERR_EOL_EARLY] = 1'b1;
        end
        if (!in_stream.tlast && cur_x == X_LAST) begin
          err_new[ERR_EOL_LATE] = 1'b1;
        end

        state_d = ACTIVE;
        sum_d   = cur_sum;
        if (!eol) begin
          x_d = cur_x + 1'b1;
          y_d = cur_y;
        end else if (cur_y == Y_LAST) begin
          state_d = WAIT_SOF;
          x_d     = '0;
          y_d     = '0;
          sum_d   = '0;
          done_d  = 1'b1;
          chk_d   = cur_sum;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          x_d = '0;
          y_d = cur_y + 1'b1;
        end
      end
    end

    // A clear never masks an error detected in the same cycle.
    err_d = (err_q & ~{ERR_W{err_clear}}) | err_new;
  end

  always_ff @(posedge in_stream_aclk or posedge in_stream_areset) begin
    if (in_stream_areset) begin
      state_q    <= WAIT_SOF;
      x_q        <= '0;
      y_q        <= '0;
      sum_q      <= '0;
      chk_q      <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      done_q     <= 1'b0;
      rdy_pipe_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sum_q      <= sum_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      rdy_pipe_q <= {rdy_pipe_q[0], 1'b1};
    end
  end

  assign err_flags      = err_q;
  assign frame_done     = done_q;
  assign frame_count    = cnt_q;
  assign frame_checksum = chk_q;
  assign dropped_beats  = drop_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Bench for pixel_stream_sink with a 4x2 frame: directed vector table, reset sequences,
// ten back-to-back frames and a randomized run against a frame-level reference model.
module tb_pixel_stream_sink;
  import pixel_stream_pkg::*;

  localparam int XS = 4;
  localparam int YS = 2;

  logic        clk;
  logic        rst;
  logic        err_clear;
  logic [4:0]  err_flags;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;
  logic [15:0] dropped_beats;
  logic [0:0]  dbg_state;

  pixel_stream_if in_if ();

  pixel_stream_sink #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .in_stream_aclk   (clk),
    .in_stream_areset (rst),
    .in_stream        (in_if),
    .err_clear        (err_clear),
    .err_flags        (err_flags),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .frame_checksum   (frame_checksum),
    .dropped_beats    (dropped_beats),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit          m_in_frame;
  int          m_col, m_line, m_since;
  logic [31:0] m_sum, m_chk;
  logic [4:0]  m_flags;
  logic [15:0] m_dropped, m_count, m_lfsr;
  bit          m_done;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
`ifdef PIXEL_SINK_STALL_EN
    return (m_since >= 2) && (m_lfsr[1:0] != 2'b00);
`else
    return (m_since >= 2);
`endif
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_col = 0; m_line = 0; m_since = 0;
    m_sum = 0; m_chk = 0; m_flags = 0; m_dropped = 0; m_count = 0;
    m_lfsr = 16'hACE1; m_done = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit acc, input logic [31:0] d, input logic [3:0] k,
                            input bit u, input bit l, input bit clr);
    logic [4:0] nw;
    nw = '0;
    m_done = 0;
    if (m_since < 2) m_since++;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (acc) begin
      if (k != 4'hF) nw[4] = 1'b1;
      if (!m_in_frame && !u) begin
        nw[0] = 1'b1;
        if (m_dropped != 16'hFFFF) m_dropped++;
      end else begin
        if (u) begin
          if (m_in_frame && (m_col != 0 || m_line != 0)) nw[1] = 1'b1;
          m_col = 0; m_line = 0; m_sum = d; m_in_frame = 1;
        end else begin
          m_sum = m_sum + d;
        end
        if (l && m_col < XS - 1) nw[2] = 1'b1;
        if (!l && m_col == XS - 1) nw[3] = 1'b1;
        if (l || m_col == XS - 1) begin
          m_col = 0;
          if (m_line == YS - 1) begin
            m_line = 0; m_in_frame = 0; m_count++; m_done = 1;
            exp_q.push_back(m_sum);
            m_sum = 0;
          end else begin
            m_line++;
          end
        end else begin
          m_col++;
        end
      end
    end
    m_flags = (clr ? 5'b0 : m_flags) | nw;
  endtask

  // ---------------- driver ----------------
  // One clock: sample tready, step model at the edge, compare outputs at the falling edge.
  task automatic tick(output bit acc);
    bit rdy;
    rdy = in_if.tready;
    check("tready", {31'b0, rdy}, {31'b0, m_rdy()});
    @(posedge clk);
    acc = in_if.tvalid && rdy && !rst;
    if (rst) model_reset();
    else model_step(acc, in_if.tdata, in_if.tkeep, in_if.tuser, in_if.tlast, err_clear);
    @(negedge clk);
    if (exp_q.size() > 0) m_chk = exp_q.pop_front();
    check("frame_done", frame_done, m_done);
    check("err_flags", err_flags, m_flags);
    check("dropped_beats", dropped_beats, m_dropped);
    check("frame_count", frame_count, m_count);
    check("frame_checksum", frame_checksum, m_chk);
    check("state", dbg_state, m_in_frame);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit u,
                           input bit l, input bit clr);
    bit ok;
    in_if.tvalid = 1'b1; in_if.tdata = d; in_if.tkeep = k;
    in_if.tuser = u; in_if.tlast = l; err_clear = clr;
    ok = 0;
    for (int n = 0; n < 64 && !ok; n++) tick(ok);
    check("accept_timeout", ok, 1);
    in_if.tvalid = 1'b0; in_if.tuser = 1'b0; in_if.tlast = 1'b0; err_clear = 1'b0;
  endtask

  task automatic send_clean_frame(input int base);
    for (int i = 0; i < XS * YS; i++) send_beat(base + i + 1, 4'hF, i == 0, (i % XS) == XS - 1, 0);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] d;
    bit          u, l;
    logic [3:0]  k;
    bit          clr, dn;
    logic [4:0]  f;
    logic [15:0] dr;
    logic [31:0] s;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [31:0] d, bit u, bit l, logic [3:0] k, bit clr,
                              bit dn, logic [4:0] f, logic [15:0] dr, logic [31:0] s);
    vec_t v;
    v.d = d; v.u = u; v.l = l; v.k = k; v.clr = clr;
    v.dn = dn; v.f = f; v.dr = dr; v.s = s;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [31:0] s;

    // clean frame 1..8
    vq.push_back(mk(1, 1, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(2, 0, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(3, 0, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(4, 0, 1, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(5, 0, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(6, 0, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(7, 0, 0, 4'hF, 0, 0, 5'h00, 0, 0));
    vq.push_back(mk(8, 0, 1, 4'hF, 0, 1, 5'h00, 0, 36));
    // three beats without start of frame, then a clean frame
    vq.push_back(mk(100, 0, 0, 4'hF, 0, 0, 5'h01, 1, 0));
    vq.push_back(mk(101, 0, 0, 4'hF, 0, 0, 5'h01, 2, 0));
    vq.push_back(mk(102, 0, 0, 4'hF, 0, 0, 5'h01, 3, 0));
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(i + 1, i == 0, (i % 4) == 3, 4'hF, 0, i == 7, 5'h01, 3, (i == 7) ? 36 : 0));
    // early start of frame on beat 3, cleared in the same cycle as the new error
    vq.push_back(mk(10, 1, 0, 4'hF, 0, 0, 5'h01, 3, 0));
    vq.push_back(mk(11, 0, 0, 4'hF, 0, 0, 5'h01, 3, 0));
    vq.push_back(mk(20, 1, 0, 4'hF, 1, 0, 5'h02, 3, 0));
    for (int i = 1; i < 8; i++)
      vq.push_back(mk(20 + i, 0, (i % 4) == 3, 4'hF, 0, i == 7, 5'h02, 3, (i == 7) ? 188 : 0));
    // early end of line 0
    vq.push_back(mk(30, 1, 0, 4'hF, 1, 0, 5'h00, 3, 0));
    vq.push_back(mk(31, 0, 1, 4'hF, 0, 0, 5'h04, 3, 0));
    vq.push_back(mk(32, 0, 0, 4'hF, 0, 0, 5'h04, 3, 0));
    vq.push_back(mk(33, 0, 0, 4'hF, 0, 0, 5'h04, 3, 0));
    vq.push_back(mk(34, 0, 0, 4'hF, 0, 0, 5'h04, 3, 0));
    vq.push_back(mk(35, 0, 1, 4'hF, 0, 1, 5'h04, 3, 195));
    // late end of line, partial keep, early end on the last line closes the frame
    vq.push_back(mk(40, 1, 0, 4'hF, 1, 0, 5'h00, 3, 0));
    vq.push_back(mk(41, 0, 0, 4'hF, 0, 0, 5'h00, 3, 0));
    vq.push_back(mk(42, 0, 0, 4'hF, 0, 0, 5'h00, 3, 0));
    vq.push_back(mk(43, 0, 0, 4'hF, 0, 0, 5'h08, 3, 0));
    vq.push_back(mk(44, 0, 0, 4'h3, 0, 0, 5'h18, 3, 0));
    vq.push_back(mk(45, 0, 1, 4'hF, 0, 1, 5'h1C, 3, 255));

    rst = 1'b1; err_clear = 1'b0;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = 4'hF;
    in_if.tuser = 1'b0; in_if.tlast = 1'b0;
    model_reset();
    @(negedge clk);
    idle(2);
    check("reset_tready", in_if.tready, 0);
    check("reset_flags", err_flags, 0);
    check("reset_count", frame_count, 0);
    check("reset_checksum", frame_checksum, 0);
    check("reset_dropped", dropped_beats, 0);
    rst = 1'b0;
    idle(1);
    check("tready_first_cycle", in_if.tready, 0);
    idle(1);

    for (int i = 0; i < vq.size(); i++) begin
      send_beat(vq[i].d, vq[i].k, vq[i].u, vq[i].l, vq[i].clr);
      check($sformatf("vec%0d_done", i), frame_done, vq[i].dn);
      check($sformatf("vec%0d_flags", i), err_flags, vq[i].f);
      check($sformatf("vec%0d_dropped", i), dropped_beats, vq[i].dr);
      if (vq[i].dn) check($sformatf("vec%0d_checksum", i), frame_checksum, vq[i].s);
    end
    check("table_frame_count", frame_count, 5);

    // reset after beat 5 discards the partial frame
    for (int i = 0; i < 5; i++) send_beat(i + 1, 4'hF, i == 0, i == 3, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("midreset_count", frame_count, 0);
    send_clean_frame(0);
    check("midreset_done", frame_done, 1);
    check("midreset_new_count", frame_count, 1);
    check("midreset_checksum", frame_checksum, 36);

    // ten back-to-back clean frames with tvalid held high
    for (int f = 0; f < 10; f++) begin
      s = 0;
      for (int i = 0; i < XS * YS; i++) s = s + 32'(f * 8 + i + 1);
      send_clean_frame(f * 8);
      check($sformatf("burst%0d_checksum", f), frame_checksum, s);
    end
    check("burst_count", frame_count, 11);
    check("burst_flags", err_flags, 0);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      in_if.tvalid = ($urandom_range(0, 3) != 0);
      in_if.tdata  = $urandom();
      in_if.tkeep  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      in_if.tuser  = m_in_frame ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) != 0);
      in_if.tlast  = (m_col == XS - 1) ^ ($urandom_range(0, 9) == 0);
      err_clear    = ($urandom_range(0, 15) == 0);
      tick(acc);
    end
    in_if.tvalid = 1'b0;
    err_clear = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
